// File: rtl/updown_button_conditioner.sv
// Up/down pushbutton conditioner: sync, debounce, press FSM.
// Turns raw buttons into single-cycle count-enable pulses.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   btn_up      raw up pushbutton (asynchronous)
//   btn_down    raw down pushbutton (asynchronous)
//   up_pulse    one-cycle count-up enable
//   down_pulse  one-cycle count-down enable
//   up_level    debounced up level
//   down_level  debounced down level
//   locked      high while both-buttons lockout is active
module updown_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_level,
  output logic down_level,
  output logic locked
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int T_MAX = (REPEAT_DELAY > REPEAT_RATE) ?
                         REPEAT_DELAY : REPEAT_RATE;
  localparam int T_W   = $clog2(T_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [T_W-1:0] T_DELAY = T_W'(REPEAT_DELAY);
  localparam logic [T_W-1:0] T_RATE  = T_W'(REPEAT_RATE);
  localparam logic [T_W-1:0] T_ONE   = T_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    LOCK
  } state_t;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      lvl;
  logic [DB_W-1:0] db_cnt [2];

  state_t         state;
  logic [T_W-1:0] timer;

  // Level flips on the edge where the mismatch run
  // would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      lvl       <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_down, btn_up};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            lvl[i]    <= ~lvl[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign up_level   = lvl[0];
  assign down_level = lvl[1];

  // A hold state checks its own level first, so a release
  // coinciding with the other press returns to IDLE and is
  // seen there as a fresh press, not as a lockout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      locked     <= 1'b0;
    end else begin
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lvl[0] && lvl[1]) begin
            state  <= LOCK;
            locked <= 1'b1;
          end else if (lvl[0]) begin
            up_pulse <= 1'b1;
            timer    <= T_DELAY;
            state    <= HOLD_UP;
          end else if (lvl[1]) begin
            down_pulse <= 1'b1;
            timer      <= T_DELAY;
            state      <= HOLD_DN;
          end
        end
        HOLD_UP: begin
          if (!lvl[0]) begin
            state <= IDLE;
          end else if (lvl[1]) begin
            state  <= LOCK;
            locked <= 1'b1;
          end else if (REPEAT_EN != 0) begin
            if (timer <= T_ONE) begin
              up_pulse <= 1'b1;
              timer    <= T_RATE;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        HOLD_DN: begin
          if (!lvl[1]) begin
            state <= IDLE;
          end else if (lvl[0]) begin
            state  <= LOCK;
            locked <= 1'b1;
          end else if (REPEAT_EN != 0) begin
            if (timer <= T_ONE) begin
              down_pulse <= 1'b1;
              timer      <= T_RATE;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        LOCK: begin
          if (!lvl[0] && !lvl[1]) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
